// File: rtl/theia_omem_reader.sv
// Host-side reader for the THEIA per-core output memories: once all cores commit, it walks
// every OMEM bank, buffers the returned words and streams them to a sink, then pulses GACK.
module theia_omem_reader #(
    parameter int WB_WIDTH   = 32,
    parameter int NUM_CORES  = 4,
    parameter int CORE_BITS  = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 CLK_I,
    input  logic                 RST_I,
    input  logic                 START_I,
    input  logic [WB_WIDTH-1:0]  CNT_I,
    input  logic [WB_WIDTH-1:0]  BASE_I,
    input  logic                 RCOMMIT_I,
    output logic [CORE_BITS-1:0] OMBSEL_O,
    output logic [WB_WIDTH-1:0]  OMADR_O,
    input  logic [WB_WIDTH-1:0]  OMEM_I,
    output logic [WB_WIDTH-1:0]  DAT_O,
    output logic [CORE_BITS-1:0] CORE_O,
    output logic                 LAST_O,
    output logic                 VLD_O,
    input  logic                 RDY_I,
    output logic                 GACK_O,
    output logic                 BUSY_O,
    output logic [2:0]           DBG_STATE_O
);

    localparam int PW = $clog2(FIFO_DEPTH);

    // DBG_STATE_O encoding: 0 IDLE, 1 WAIT, 2 READ, 3 DRAIN, 4 ACK.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_ACK   = 3'd4
    } state_t;

    state_t                state_q;
    logic [WB_WIDTH-1:0]   cnt_q, base_q, idx_q;
    logic [CORE_BITS-1:0]  core_q;
    logic [CORE_BITS-1:0]  sel_q;
    logic [WB_WIDTH-1:0]   adr_q;
    logic                  infl_q, infl_last_q;
    logic [CORE_BITS-1:0]  infl_core_q;
    logic [WB_WIDTH-1:0]   dat_mem_q  [FIFO_DEPTH];
    logic [CORE_BITS-1:0]  core_mem_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] last_mem_q;
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [PW:0]           count_q, count_d;
    logic                  gack_q, busy_q;

    logic                  pop, issue, last_idx, last_core;
    logic [PW+1:0]         occ;

    // Sink handshake: a word moves when VLD_O & RDY_I at a rising edge. VLD_O reflects a
    // non-empty FIFO and the head entry only changes on a pop, so a stalled word holds
    // stable and VLD_O never falls without a transfer.
    assign VLD_O  = (count_q != '0);
    assign DAT_O  = dat_mem_q[rd_ptr_q];
    assign CORE_O = core_mem_q[rd_ptr_q];
    assign LAST_O = last_mem_q[rd_ptr_q];
    assign GACK_O = gack_q;
    assign BUSY_O = busy_q;
    assign DBG_STATE_O = state_q;

    assign pop       = VLD_O & RDY_I;
    assign last_idx  = (idx_q == cnt_q - WB_WIDTH'(1));
    assign last_core = (core_q == CORE_BITS'(NUM_CORES - 1));

    // Buffered plus in-flight words may never exceed the FIFO, counting this cycle's pop.
    assign occ   = (PW+2)'(count_q) + (PW+2)'(infl_q) - (PW+2)'(pop);
    assign issue = (state_q == S_READ) && (occ < (PW+2)'(FIFO_DEPTH));

    assign OMBSEL_O = issue ? core_q : sel_q;
    assign OMADR_O  = issue ? (base_q + idx_q) : adr_q;
    assign count_d  = count_q + (PW+1)'(infl_q) - (PW+1)'(pop);

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            base_q      <= '0;
            idx_q       <= '0;
            core_q      <= '0;
            sel_q       <= '0;
            adr_q       <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            infl_core_q <= '0;
            last_mem_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            gack_q      <= 1'b0;
            busy_q      <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                dat_mem_q[i]  <= '0;
                core_mem_q[i] <= '0;
            end
        end else begin
            // The word addressed now returns on OMEM_I next cycle; its tags travel with it.
            infl_q <= issue;
            if (issue) begin
                sel_q       <= core_q;
                adr_q       <= base_q + idx_q;
                infl_core_q <= core_q;
                infl_last_q <= last_idx & last_core;
            end

            if (infl_q) begin
                dat_mem_q[wr_ptr_q]  <= OMEM_I;
                core_mem_q[wr_ptr_q] <= infl_core_q;
                last_mem_q[wr_ptr_q] <= infl_last_q;
                wr_ptr_q             <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;

            gack_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (START_I) begin
                        cnt_q   <= CNT_I;
                        base_q  <= BASE_I;
                        core_q  <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (RCOMMIT_I) begin
                        if (cnt_q == '0) begin
                            gack_q  <= 1'b1;
                            state_q <= S_ACK;
                        end else begin
                            state_q <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (issue) begin
                        if (last_idx) begin
                            idx_q  <= '0;
                            core_q <= core_q + CORE_BITS'(1);
                        end else begin
                            idx_q <= idx_q + WB_WIDTH'(1);
                        end
                        if (last_idx && last_core) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!infl_q && (count_q == '0)) begin
                        gack_q  <= 1'b1;
                        state_q <= S_ACK;
                    end
                end
                S_ACK: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_theia_omem_reader.sv
// Bench for theia_omem_reader: a THEIA OMEM model answers reads one cycle later, and every
// issued address and streamed word is scored against lists built from the pass parameters.
module tb_theia_omem_reader;

    localparam int W     = 35;  // scoreboard entry: {core[1:0], last, data[31:0]}
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        RST_I, START_I, RCOMMIT_I, RDY_I;
    logic [31:0] CNT_I, BASE_I, OMEM_I;
    logic [1:0]  OMBSEL_O, CORE_O;
    logic [31:0] OMADR_O, DAT_O;
    logic        LAST_O, VLD_O, GACK_O, BUSY_O;
    logic [2:0]  DBG_STATE_O;

    always #5 clk = ~clk;

    theia_omem_reader #(
        .WB_WIDTH(32), .NUM_CORES(4), .CORE_BITS(2), .FIFO_DEPTH(DEPTH)
    ) dut (
        .CLK_I(clk), .RST_I(RST_I), .START_I(START_I), .CNT_I(CNT_I), .BASE_I(BASE_I),
        .RCOMMIT_I(RCOMMIT_I), .OMBSEL_O(OMBSEL_O), .OMADR_O(OMADR_O), .OMEM_I(OMEM_I),
        .DAT_O(DAT_O), .CORE_O(CORE_O), .LAST_O(LAST_O), .VLD_O(VLD_O), .RDY_I(RDY_I),
        .GACK_O(GACK_O), .BUSY_O(BUSY_O), .DBG_STATE_O(DBG_STATE_O)
    );

    // Bank contents: depend on both bank and address so a wrong select shows in the data.
    function automatic logic [31:0] omem_fn(input logic [1:0] s, input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ {s, s, 28'h5A5A5A5};
    endfunction

    always @(posedge clk) OMEM_I <= omem_fn(OMBSEL_O, OMADR_O);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [W-1:0]  exp_q[$];
    logic [33:0]   adr_q[$];
    int            n_checks = 0, n_pass = 0;
    int            issues = 0, xfers = 0, gack_cnt = 0;
    int            first_vld_cyc = -1, gack_cyc = -1, commit_cyc = 0;
    int            rdy_mode = 0;
    logic [33:0]   prev_ia = '0;
    logic          stalled_prev = 1'b0;
    logic [W-1:0]  stall_word = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Observer on the falling edge: issue order, occupancy bound, stream order, stall hold.
    always @(negedge clk) begin
        if (!RST_I) begin
            if (stalled_prev) begin
                check("stall_vld_held", VLD_O, 1);
                check("stall_word_held", {CORE_O, LAST_O, DAT_O}, stall_word);
            end
            if (VLD_O && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (VLD_O && RDY_I) begin
                xfers++;
                if (exp_q.size() > 0) check("stream_word", {CORE_O, LAST_O, DAT_O}, exp_q.pop_front());
                else check("extra_word", {CORE_O, LAST_O, DAT_O}, 64'hFFFF_0000_0000_0000);
            end
            if (BUSY_O && ({OMBSEL_O, OMADR_O} != prev_ia)) begin
                issues++;
                if (adr_q.size() > 0) check("issue_addr", {OMBSEL_O, OMADR_O}, adr_q.pop_front());
                else check("extra_issue", {OMBSEL_O, OMADR_O}, 64'hFFFF_0000_0000_0000);
                check("occupancy_le_depth", (issues - xfers) <= DEPTH, 1);
            end
            stalled_prev = VLD_O && !RDY_I;
            stall_word   = {CORE_O, LAST_O, DAT_O};
            if (GACK_O) begin
                gack_cnt++;
                gack_cyc = cyc;
            end
        end else begin
            stalled_prev = 1'b0;
        end
        prev_ia = {OMBSEL_O, OMADR_O};
    end

    task automatic step();
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       RDY_I = 1'b1;
            1:       RDY_I = ~RDY_I;
            default: RDY_I = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic build_expect(input int cnt, input logic [31:0] base);
        exp_q.delete();
        adr_q.delete();
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < cnt; i++) begin
                logic [31:0] a;
                a = base + i;
                exp_q.push_back({2'(c), (c == 3 && i == cnt - 1), omem_fn(2'(c), a)});
                adr_q.push_back({2'(c), a});
            end
        end
        issues = 0; xfers = 0; gack_cnt = 0; first_vld_cyc = -1; gack_cyc = -1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_vld"},   VLD_O, 0);
        check({tag, "_gack"},  GACK_O, 0);
        check({tag, "_busy"},  BUSY_O, 0);
        check({tag, "_omsel"}, OMBSEL_O, 0);
        check({tag, "_omadr"}, OMADR_O, 0);
        check({tag, "_dat"},   {CORE_O, LAST_O, DAT_O}, 0);
        check({tag, "_state"}, DBG_STATE_O, 0);
    endtask

    task automatic start_pass(input int cnt, input logic [31:0] base, input int mode);
        build_expect(cnt, base);
        rdy_mode = mode;
        CNT_I = cnt; BASE_I = base; START_I = 1'b1;
        step();
        START_I = 1'b0; CNT_I = '0; BASE_I = '0;
        check("busy_after_start", BUSY_O, 1);
    endtask

    task automatic commit();
        RCOMMIT_I  = 1'b1;
        commit_cyc = cyc;
        step();
        RCOMMIT_I = 1'b0;
    endtask

    task automatic run_pass(input int cnt, input logic [31:0] base, input int mode,
                            input int delay, input bit dup);
        int budget;
        start_pass(cnt, base, mode);
        if (dup) begin
            CNT_I = cnt + 3; BASE_I = base + 32'h100; START_I = 1'b1;
            step();
            START_I = 1'b0; CNT_I = '0; BASE_I = '0;
        end
        repeat (delay) step();
        check("no_issue_before_commit", issues, 0);
        check("no_vld_before_commit", VLD_O, 0);
        commit();
        budget = 0;
        while (gack_cnt == 0 && budget < 3000) begin
            step();
            budget++;
        end
        check("gack_seen", gack_cnt > 0, 1);
        repeat (4) step();
        check("gack_once", gack_cnt, 1);
        check("words_left", exp_q.size(), 0);
        check("issues_left", adr_q.size(), 0);
        check("issue_total", issues, 4 * cnt);
        check("xfer_total", xfers, 4 * cnt);
        check("busy_end", BUSY_O, 0);
        if (cnt > 0) begin
            check("first_word_latency", first_vld_cyc - commit_cyc, 3);
        end else begin
            check("gack_latency_cnt0", gack_cyc - commit_cyc, 1);
            check("vld_never_cnt0", first_vld_cyc, -1);
        end
    endtask

    initial begin
        int budget;
        RST_I = 1'b1; START_I = 1'b0; RCOMMIT_I = 1'b0; RDY_I = 1'b1;
        CNT_I = '0; BASE_I = '0;
        repeat (3) step();
        check_idle_outputs("reset");
        RST_I = 1'b0;
        step();

        run_pass(3, 32'h10, 0, 3, 1'b0);            // full-rate pass
        run_pass(4, 32'h40, 1, 2, 1'b0);            // sink alternates ready
        run_pass(0, 32'h80, 0, 2, 1'b0);            // empty pass
        run_pass(4, 32'hFFFF_FFFE, 0, 1, 1'b0);     // address wrap
        run_pass(2, 32'h500, 0, 2, 1'b1);           // second START while busy

        // Reset in the middle of a pass, then a fresh pass must complete.
        start_pass(4, 32'h200, 0);
        repeat (2) step();
        commit();
        budget = 0;
        while (xfers < 5 && budget < 200) begin
            step();
            budget++;
        end
        check("mid_pass_words", xfers >= 5, 1);
        RST_I = 1'b1;
        step();
        RST_I = 1'b0;
        check_idle_outputs("midreset");
        gack_cnt = 0;
        repeat (5) step();
        check("no_gack_after_reset", gack_cnt, 0);
        run_pass(4, 32'h300, 2, 3, 1'b0);

        for (int r = 0; r < 4; r++) begin
            run_pass($urandom_range(1, 6), $urandom | 32'h1, 2, $urandom_range(0, 4), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
